// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: register-zero index, MDU latencies, SPECIAL funct codes
// and the decode helper that derives the MDU/HI-LO class bits for the ID stage.
package mips_pkg;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         MUL_CYC_DEF = 5;
  localparam int         DIV_CYC_DEF = 32;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;

  typedef enum logic [1:0] {
    SCHED_RUN,
    SCHED_STALL,
    SCHED_FLUSH
  } sched_e;

  typedef struct packed {
    logic mdu_start;
    logic is_div;
    logic reads_hilo;
  } mdu_dec_t;

  function automatic mdu_dec_t decode_mdu(input logic [5:0] opcode, input logic [5:0] funct);
    mdu_dec_t d;
    d = '0;
    if (opcode == OP_SPECIAL) begin
      case (funct)
        FN_MULT, FN_MULTU:                   d.mdu_start  = 1'b1;
        FN_DIV, FN_DIVU:                     d            = '{mdu_start: 1'b1, is_div: 1'b1, reads_hilo: 1'b0};
        FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO:  d.reads_hilo = 1'b1;
        default:                             d            = '0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/mdu_busy_timer.sv
// Countdown of remaining MDU occupancy: loaded when a MULT/DIV issues, busy while nonzero.
module mdu_busy_timer #(
  parameter int MUL_CYC = 5,
  parameter int DIV_CYC = 32,
  parameter int CNT_W   = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic is_div,
  output logic busy
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = is_div ? CNT_W'(DIV_CYC) : CNT_W'(MUL_CYC);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage scheduler: resolves load-use, HI/LO occupancy and taken-branch flushes,
// and drives the PC / IF-ID / ID-EX controls plus a saturating stall counter.
module id_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MUL_CYC = MUL_CYC_DEF,
  parameter int DIV_CYC = DIV_CYC_DEF,
  parameter int CNT_W   = 6,
  parameter int PERF_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_mdu_start,
  input  logic              id_is_div,
  input  logic              id_reads_hilo,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_br_taken,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              mdu_issue,
  output logic              mdu_busy,
  output logic [PERF_W-1:0] stall_cnt
);

  logic              lu, mh, stall;
  sched_e            sched;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  // Load into $0 never creates a dependency since $0 is hardwired.
  assign lu = id_valid & ex_valid & ex_mem_read & (ex_rt != '0) &
              ((id_uses_rs & (id_rs == ex_rt)) | (id_uses_rt & (id_rt == ex_rt)));
  assign mh    = id_valid & mdu_busy & (id_reads_hilo | id_mdu_start);
  assign stall = (lu | mh) & ~ex_br_taken;

  always_comb begin
    // NOTE: every output is defaulted before branching so no path can infer a latch.
    sched       = SCHED_RUN;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    mdu_issue   = 1'b0;
    if (ex_br_taken) sched = SCHED_FLUSH;
    else if (stall)  sched = SCHED_STALL;
    case (sched)
      SCHED_FLUSH: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      SCHED_STALL: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
      end
      SCHED_RUN:   mdu_issue = id_valid & id_mdu_start;
      default:     ;
    endcase
  end

  // Busy-stalling keeps mdu_issue low while counting, so the timer never reloads mid-count.
  mdu_busy_timer #(
    .MUL_CYC(MUL_CYC),
    .DIV_CYC(DIV_CYC),
    .CNT_W  (CNT_W)
  ) u_mdu_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (mdu_issue),
    .is_div(id_is_div),
    .busy  (mdu_busy)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((sched == SCHED_STALL) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed and randomized checks of id_hazard_ctrl against a rule-level reference model;
// a second instance with a 4-bit perf counter exercises saturation.
module tb_id_hazard_ctrl;

  localparam int REG_AW  = 5;
  localparam int MUL_CYC = 5;
  localparam int DIV_CYC = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              id_valid, id_uses_rs, id_uses_rt, id_mdu_start, id_is_div, id_reads_hilo;
  logic [REG_AW-1:0] id_rs, id_rt, ex_rt;
  logic              ex_valid, ex_mem_read, ex_br_taken;

  logic        pc_we, ifid_we, ifid_flush, idex_bubble, mdu_issue, mdu_busy;
  logic [15:0] stall_cnt;
  logic        s_pc_we, s_ifid_we, s_ifid_flush, s_idex_bubble, s_mdu_issue, s_mdu_busy;
  logic [3:0]  s_stall_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int m_busy   = 0;   // model: remaining MDU busy cycles
  int m_stall  = 0;   // model: 16-bit stall count
  int m_stall4 = 0;   // model: 4-bit stall count

  always #5 clk = ~clk;

  id_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_mdu_start(id_mdu_start),
    .id_is_div(id_is_div), .id_reads_hilo(id_reads_hilo), .ex_valid(ex_valid),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_br_taken(ex_br_taken),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .mdu_issue(mdu_issue), .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
  );

  id_hazard_ctrl #(.PERF_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_mdu_start(id_mdu_start),
    .id_is_div(id_is_div), .id_reads_hilo(id_reads_hilo), .ex_valid(ex_valid),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_br_taken(ex_br_taken),
    .pc_we(s_pc_we), .ifid_we(s_ifid_we), .ifid_flush(s_ifid_flush),
    .idex_bubble(s_idex_bubble), .mdu_issue(s_mdu_issue), .mdu_busy(s_mdu_busy),
    .stall_cnt(s_stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_mdu_start = 0; id_is_div = 0; id_reads_hilo = 0;
    ex_valid = 0; ex_mem_read = 0; ex_rt = 0; ex_br_taken = 0;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                        input logic urt);
    id_valid = 1; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
    id_mdu_start = 0; id_is_div = 0; id_reads_hilo = 0;
  endtask

  task automatic set_load(input logic [4:0] rt);
    ex_valid = 1; ex_mem_read = 1; ex_rt = rt;
  endtask

  // One clock: inputs already applied just after the previous edge.
  task automatic cyc(input string tag);
    bit lu, mh, stall, iss, busy;
    logic [5:0] exp_ctl;
    busy  = (m_busy > 0);
    lu    = id_valid && ex_valid && ex_mem_read && (ex_rt != 0) &&
            ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
    mh    = id_valid && busy && (id_reads_hilo || id_mdu_start);
    stall = (lu || mh) && !ex_br_taken;
    iss   = !ex_br_taken && !stall && id_valid && id_mdu_start;
    if (ex_br_taken) exp_ctl = {4'b1111, 1'b0, busy};
    else if (stall)  exp_ctl = {4'b0001, 1'b0, busy};
    else             exp_ctl = {4'b1100, iss, busy};
    #3;
    check({tag, "_ctl"}, 32'({pc_we, ifid_we, ifid_flush, idex_bubble, mdu_issue, mdu_busy}),
          32'(exp_ctl));
    check({tag, "_ctl4"}, 32'({s_pc_we, s_ifid_we, s_ifid_flush, s_idex_bubble, s_mdu_issue,
          s_mdu_busy}), 32'(exp_ctl));
    check({tag, "_scnt"}, 32'(stall_cnt), 32'(m_stall));
    check({tag, "_scnt4"}, 32'(s_stall_cnt), 32'(m_stall4));
    @(posedge clk);
    #1;
    if (iss)         m_busy = id_is_div ? DIV_CYC : MUL_CYC;
    else if (busy)   m_busy--;
    if (stall) begin
      if (m_stall < 65535) m_stall++;
      if (m_stall4 < 15)   m_stall4++;
    end
  endtask

  initial begin
    idle();
    #1;
    check("rst_ctl", 32'({pc_we, ifid_we, ifid_flush, idex_bubble, mdu_issue, mdu_busy}),
          32'b110000);
    check("rst_scnt", 32'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // 1: LW $8 in EX, ADD $9,$8,$1 in ID -> one stall, then run.
    set_load(8); set_id(8, 1, 1, 1);
    cyc("t1_stall");
    check("t1_scnt", 32'(stall_cnt), 1);
    ex_valid = 0; ex_mem_read = 0;
    cyc("t1_run");

    // 2: load into $0 is harmless; rs match stalls even with rt unused; rt-only match ignored.
    set_load(0); set_id(0, 1, 0, 1);
    cyc("t2_zero");
    set_load(8); set_id(8, 1, 8, 0);
    cyc("t2_rs");
    set_id(1, 1, 8, 0);
    cyc("t2_rt_unused");
    check("t2_scnt", 32'(stall_cnt), 2);
    idle();

    // 3: MULT issues, MFLO waits MUL_CYC cycles then advances.
    set_id(2, 1, 3, 1); id_mdu_start = 1;
    cyc("t3_mult");
    set_id(0, 0, 0, 0); id_reads_hilo = 1;
    for (int i = 0; i < MUL_CYC + 1; i++) cyc("t3_mflo");
    check("t3_scnt", 32'(stall_cnt), 7);
    idle();

    // 4: DIV occupies MDU; a following MULT waits DIV_CYC cycles then issues.
    set_id(4, 1, 5, 1); id_mdu_start = 1; id_is_div = 1;
    cyc("t4_div");
    id_is_div = 0;
    for (int i = 0; i < DIV_CYC + 1; i++) cyc("t4_mult");
    check("t4_scnt", 32'(stall_cnt), 39);
    idle();
    for (int i = 0; i < MUL_CYC; i++) cyc("t4_drain");

    // 5: taken branch beats a load-use hazard and kills an ID DIV.
    set_load(8); set_id(8, 1, 8, 1); id_mdu_start = 1; id_is_div = 1; ex_br_taken = 1;
    cyc("t5_flush");
    check("t5_scnt", 32'(stall_cnt), 39);
    idle();
    set_id(1, 1, 2, 1); id_mdu_start = 1;
    cyc("t5_mult");
    set_id(0, 0, 0, 0); id_reads_hilo = 1; ex_br_taken = 1;
    cyc("t5_flush_busy");
    idle();
    for (int i = 0; i < MUL_CYC; i++) cyc("t5_drain");

    // 6: async reset part-way through a divide clears everything at once.
    set_id(1, 1, 2, 1); id_mdu_start = 1; id_is_div = 1;
    cyc("t6_div");
    idle();
    for (int i = 0; i < DIV_CYC - 17; i++) cyc("t6_count");
    #1;
    rst_n = 0;
    #1;
    check("t6_rst_busy", 32'(mdu_busy), 0);
    check("t6_rst_scnt", 32'(stall_cnt), 0);
    check("t6_rst_scnt4", 32'(s_stall_cnt), 0);
    m_busy = 0; m_stall = 0; m_stall4 = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // Saturation: 20 consecutive load-use stalls.
    set_load(9); set_id(9, 1, 0, 0);
    for (int i = 0; i < 20; i++) cyc("sat");
    check("sat_scnt4", 32'(s_stall_cnt), 15);
    check("sat_scnt", 32'(stall_cnt), 20);
    idle();

    // Randomized traffic on a small register range so hazards are frequent.
    for (int i = 0; i < 400; i++) begin
      id_valid      = ($urandom_range(3, 0) != 0);
      id_rs         = REG_AW'($urandom_range(3, 0));
      id_rt         = REG_AW'($urandom_range(3, 0));
      id_uses_rs    = 1'($urandom_range(1, 0));
      id_uses_rt    = 1'($urandom_range(1, 0));
      id_mdu_start  = ($urandom_range(7, 0) == 0);
      id_is_div     = ($urandom_range(3, 0) == 0);
      id_reads_hilo = ($urandom_range(5, 0) == 0);
      ex_valid      = 1'($urandom_range(1, 0));
      ex_mem_read   = 1'($urandom_range(1, 0));
      ex_rt         = REG_AW'($urandom_range(3, 0));
      ex_br_taken   = ($urandom_range(7, 0) == 0);
      cyc("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
